// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW scoreboard, redirect flush and memory-wait stall control for the 5-stage pipeline.
// Define PIPE_HAZARD_PERF_EN to add hazard/flush/memstall performance counters.
module pipe_hazard_ctrl #(
    parameter int DEPTH        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ifu_valid,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic        need_rs1,
    input  logic        need_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        dec_wb_en,
    input  logic        exu_redirect,
    input  logic        mem_req,
    input  logic        mem_ack,
    output logic        hazard_nop,
    output logic        flush_nop,
    output logic        ifu_stall,
    output logic        pipe_stall,
    output logic        sb_busy
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_hazard_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memstall_cnt
`endif
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state, state_nxt;
    logic [DEPTH-1:0] v;
    logic [4:0]       rd [DEPTH];
    logic [2:0]       fcnt;
    logic             hit1, hit2, issue;

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit1 = hit1 | (v[i] && rd[i] == dec_rs1);
            hit2 = hit2 | (v[i] && rd[i] == dec_rs2);
        end
        hit1 = hit1 & need_rs1 & (dec_rs1 != 5'd0);
        hit2 = hit2 & need_rs2 & (dec_rs2 != 5'd0);
    end

    // Gating with rstn keeps the outputs quiet while reset is held, even if inputs are active.
    assign pipe_stall = rstn & mem_req & ~mem_ack;
    assign flush_nop  = rstn & (exu_redirect | (fcnt != 3'd0)) & ~pipe_stall;
    assign hazard_nop = ifu_valid & (hit1 | hit2) & ~flush_nop & ~pipe_stall;
    assign ifu_stall  = hazard_nop | pipe_stall;
    assign sb_busy    = |v;
    assign issue      = ifu_valid & ~hazard_nop & ~flush_nop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) rd[i] <= 5'd0;
        end else if (!pipe_stall) begin
            for (int i = 1; i < DEPTH; i++) begin
                v[i]  <= v[i-1];
                rd[i] <= rd[i-1];
            end
            v[0]  <= issue & dec_wb_en & (dec_rd != 5'd0);
            rd[0] <= dec_rd;
        end
    end

    // A redirect seen during a stall is dropped; the frozen EX stage presents it again.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) fcnt <= 3'd0;
        else if (!pipe_stall) begin
            if (exu_redirect) fcnt <= 3'(FLUSH_CYCLES - 1);
            else if (fcnt != 3'd0) fcnt <= fcnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? ((mem_req && !mem_ack) ? WAIT : IDLE)
                                    : (mem_ack ? IDLE : WAIT);
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_hazard_cnt   <= 32'd0;
            perf_flush_cnt    <= 32'd0;
            perf_memstall_cnt <= 32'd0;
        end else begin
            perf_hazard_cnt   <= perf_hazard_cnt + 32'(hazard_nop);
            perf_flush_cnt    <= perf_flush_cnt + 32'(flush_nop);
            perf_memstall_cnt <= perf_memstall_cnt + 32'(pipe_stall);
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a queue-based scoreboard checked by a separate monitor.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       ifu_valid = 1'b0, need_rs1 = 1'b0, need_rs2 = 1'b0, dec_wb_en = 1'b0;
    logic [4:0] dec_rs1 = 5'd0, dec_rs2 = 5'd0, dec_rd = 5'd0;
    logic       exu_redirect = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
    logic       hazard_nop, flush_nop, ifu_stall, pipe_stall, sb_busy;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_hazard_cnt, perf_flush_cnt, perf_memstall_cnt;
`endif

    typedef struct {
        string      nm;
        logic [4:0] exp;
    } exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.DEPTH(2), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rstn(rstn), .ifu_valid(ifu_valid),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .need_rs1(need_rs1), .need_rs2(need_rs2),
        .dec_rd(dec_rd), .dec_wb_en(dec_wb_en), .exu_redirect(exu_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack),
        .hazard_nop(hazard_nop), .flush_nop(flush_nop), .ifu_stall(ifu_stall),
        .pipe_stall(pipe_stall), .sb_busy(sb_busy)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_hazard_cnt(perf_hazard_cnt), .perf_flush_cnt(perf_flush_cnt),
        .perf_memstall_cnt(perf_memstall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Monitor: outputs are presented every cycle; sample on the falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({hazard_nop, flush_nop, ifu_stall, pipe_stall, sb_busy} !== e.exp) begin
                errors++;
                $display("FAIL %s: got {hz,fl,is,ps,sb}=%b expected %b", e.nm,
                         {hazard_nop, flush_nop, ifu_stall, pipe_stall, sb_busy}, e.exp);
            end
`ifdef PIPE_HAZARD_PERF_EN
            if (!rstn) begin
                checks++;
                if ({perf_hazard_cnt, perf_flush_cnt, perf_memstall_cnt} !== 96'd0) begin
                    errors++;
                    $display("FAIL %s_perf: got %0d/%0d/%0d expected 0/0/0", e.nm,
                             perf_hazard_cnt, perf_flush_cnt, perf_memstall_cnt);
                end
            end
`endif
        end
    end

    // One cycle: drive inputs just after the rising edge and queue the expected outputs.
    task automatic cyc(input string nm, input logic r, input logic v,
                       input logic n1, input logic [4:0] rs1, input logic n2, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wb, input logic redir,
                       input logic req, input logic ack, input logic [4:0] exp);
        @(posedge clk);
        #1;
        rstn = r; ifu_valid = v; need_rs1 = n1; dec_rs1 = rs1; need_rs2 = n2; dec_rs2 = rs2;
        dec_rd = rd; dec_wb_en = wb; exu_redirect = redir; mem_req = req; mem_ack = ack;
        q.push_back('{nm, exp});
    endtask

    initial begin
        //        name          rst v n1 rs1 n2 rs2 rd  wb rd req ack  {hz,fl,is,ps,sb}
        cyc("reset_hold",       0, 1, 1,  5, 0,  0, 5,  1, 1, 1, 0, 5'b00000);
        cyc("idle",             1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        // RAW on x5
        cyc("raw_issue",        1, 1, 0,  0, 0,  0, 5,  1, 0, 0, 0, 5'b00000);
        cyc("raw_ex",           1, 1, 1,  5, 0,  0, 6,  0, 0, 0, 0, 5'b10101);
        cyc("raw_mem",          1, 1, 1,  5, 0,  0, 6,  0, 0, 0, 0, 5'b10101);
        cyc("raw_clear",        1, 1, 1,  5, 0,  0, 6,  0, 0, 0, 0, 5'b00000);
        cyc("raw_idle",         1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        // x0 writes never tracked, x0 reads never hazard, unneeded rs2 ignored
        cyc("x0_issue",         1, 1, 0,  0, 0,  0, 0,  1, 0, 0, 0, 5'b00000);
        cyc("x0_read",          1, 1, 1,  0, 0,  0, 7,  1, 0, 0, 0, 5'b00000);
        cyc("rs2_not_needed",   1, 1, 1,  3, 0,  7, 0,  0, 0, 0, 0, 5'b00001);
        cyc("x7_in_mem",        1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00001);
        cyc("x7_gone",          1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        // Redirect: two flush cycles, killed writers stay out of the scoreboard
        cyc("flush_t",          1, 1, 0,  0, 0,  0, 8,  1, 1, 0, 0, 5'b01000);
        cyc("flush_t1",         1, 1, 0,  0, 0,  0, 9,  1, 0, 0, 0, 5'b01000);
        cyc("flush_t2",         1, 1, 1,  8, 1,  9, 0,  0, 0, 0, 0, 5'b00000);
        cyc("flush_idle",       1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        cyc("prio_issue",       1, 1, 0,  0, 0,  0, 10, 1, 0, 0, 0, 5'b00000);
        cyc("prio_flush_hz",    1, 1, 1, 10, 0,  0, 0,  0, 1, 0, 0, 5'b01001);
        cyc("prio_flush_hz2",   1, 1, 1, 10, 0,  0, 0,  0, 0, 0, 0, 5'b01001);
        cyc("prio_done",        1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        // Memory wait: scoreboard frozen while stalled
        cyc("mw_issue",         1, 1, 0,  0, 0,  0, 11, 1, 0, 0, 0, 5'b00000);
        cyc("mw_t",             1, 1, 1, 11, 0,  0, 12, 1, 0, 1, 0, 5'b00111);
        cyc("mw_t1",            1, 1, 1, 11, 0,  0, 12, 1, 0, 1, 0, 5'b00111);
        cyc("mw_t2",            1, 1, 1, 11, 0,  0, 12, 1, 0, 1, 0, 5'b00111);
        cyc("mw_ack_hz_ex",     1, 1, 1, 11, 0,  0, 12, 1, 0, 1, 1, 5'b10101);
        cyc("mw_hz_mem",        1, 1, 1, 11, 0,  0, 12, 1, 0, 0, 0, 5'b10101);
        cyc("mw_resume",        1, 1, 1, 11, 0,  0, 12, 1, 0, 0, 0, 5'b00000);
        cyc("zero_wait",        1, 0, 0,  0, 0,  0, 0,  0, 0, 1, 1, 5'b00001);
        cyc("zero_wait_next",   1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00001);
        cyc("zero_wait_done",   1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        // Redirect and hazard during a stall are both masked; fcnt not loaded
        cyc("ov_issue",         1, 1, 0,  0, 0,  0, 13, 1, 0, 0, 0, 5'b00000);
        cyc("ov_stalled",       1, 1, 1, 13, 0,  0, 0,  0, 1, 1, 0, 5'b00111);
        cyc("ov_ack_no_flush",  1, 1, 1, 13, 0,  0, 0,  0, 0, 1, 1, 5'b10101);
        cyc("ov_hz_mem",        1, 1, 1, 13, 0,  0, 0,  0, 0, 0, 0, 5'b10101);
        cyc("ov_done",          1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        // Async reset mid-WAIT with fcnt=1 and valid entries
        cyc("ar_issue",         1, 1, 0,  0, 0,  0, 14, 1, 0, 0, 0, 5'b00000);
        cyc("ar_redirect",      1, 0, 0,  0, 0,  0, 0,  0, 1, 0, 0, 5'b01001);
        cyc("ar_wait",          1, 1, 0,  0, 0,  0, 15, 1, 0, 1, 0, 5'b00111);
        cyc("ar_reset",         0, 1, 1, 14, 0,  0, 0,  0, 1, 1, 0, 5'b00000);
        cyc("ar_release",       1, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        cyc("ar_sb_cleared",    1, 1, 1, 14, 0,  0, 0,  0, 0, 0, 0, 5'b00000);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It keeps a small scoreboard of destination registers in flight in EX and MEM. From that scoreboard it generates hazard_nop and flush_nop for the IDU pipeline register. It also sequences a memory-wait state machine that freezes the whole pipeline while the data port is busy. It sits beside the IDU/EXU/MMU and drives only control signals; the IDU handles WB-stage forwarding itself.

Parameters:
DEPTH, 2, number of in-flight stages tracked after ID (EX, MEM); range 1..4
FLUSH_CYCLES, 2, cycles flush_nop stays high per redirect; range 1..7

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
ifu_valid  in  1  instruction at decode input is valid
dec_rs1  in  5  rs1 index of the decoding instruction
dec_rs2  in  5  rs2 index of the decoding instruction
need_rs1  in  1  decoder: instruction reads rs1
need_rs2  in  1  decoder: instruction reads rs2
dec_rd  in  5  rd index of the decoding instruction
dec_wb_en  in  1  decoding instruction writes rd (alu, load, jal, jalr)
exu_redirect  in  1  one-cycle pulse: EX resolved a taken branch or jump
mem_req  in  1  MEM stage has a load/store needing the data port
mem_ack  in  1  data port completes the access this cycle
hazard_nop  out  1  insert bubble into the ID/EX register; hold IF/ID
flush_nop  out  1  kill the instruction entering the ID/EX register
ifu_stall  out  1  hold PC and the IF/ID register
pipe_stall  out  1  freeze every pipeline register
sb_busy  out  1  at least one scoreboard entry is valid

Behaviour:
Reset (rstn=0, async):
- All scoreboard entries invalid; flush counter 0; FSM IDLE.
- Outputs: all outputs 0.

Scoreboard:
- Entry i holds {v, rd}. Entry 0 is EX, entry DEPTH-1 is MEM.
- Update on each clk edge where pipe_stall=0:
  - entry[i] <= entry[i-1] for i≥1.
  - entry[0] <= {issue & dec_wb_en & (dec_rd!=0), dec_rd}.
  - issue = ifu_valid & !hazard_nop & !flush_nop.
- While pipe_stall=1, every entry holds its value.
- sb_busy = OR of all v bits.

Hazard:
- Condition (combinational):
  - hit1 = need_rs1 & dec_rs1!=0 & any(v & rd==dec_rs1).
  - hit2 = the same using need_rs2 and dec_rs2.
- hazard_nop = ifu_valid & (hit1|hit2) & !flush_nop & !pipe_stall.
- ifu_stall = hazard_nop | pipe_stall.
- x0 never hazards.

Flush:
- flush_nop = (exu_redirect | fcnt!=0) & !pipe_stall.
- On exu_redirect with pipe_stall=0: fcnt <= FLUSH_CYCLES-1.
- Else, if fcnt!=0 and pipe_stall=0: fcnt decrements.
- A new redirect while fcnt!=0 reloads fcnt.
- A redirect arriving while pipe_stall=1 is ignored. EX is frozen, so EX re-presents it.

Priority: pipe_stall > flush_nop > hazard_nop. flush_nop and hazard_nop are never both 1.

Memory FSM:
- States: IDLE, WAIT.
- Transitions:
  - IDLE→WAIT when mem_req & !mem_ack.
  - WAIT→IDLE when mem_ack.
  - WAIT stays in WAIT otherwise.
  - mem_req dropping in WAIT is illegal; the FSM stays in WAIT.
- pipe_stall = mem_req & !mem_ack, in either state.
- A zero-wait ack (req and ack in the same cycle) never stalls.
- The cycle mem_ack arrives is not stalled; the pipeline advances on that edge.

Reset mid-operation clears the FSM, scoreboard and fcnt immediately, with no output glitch beyond reset.

Optional Feature:
Macro: PIPE_HAZARD_PERF_EN.
- When defined, adds the following ports, each counting on clk, reset to 0, wrapping at 2^32:
  - perf_hazard_cnt  out  32: +1 per cycle hazard_nop=1.
  - perf_flush_cnt  out  32: +1 per cycle flush_nop=1.
  - perf_memstall_cnt  out  32: +1 per cycle pipe_stall=1.
- When undefined, the ports and counters are absent and all other behaviour is identical.

Test Plan:
1. RAW on x5 (DEPTH=2):
   - Stimulus: issue dec_rd=5, dec_wb_en=1. Next cycle decode need_rs1=1, dec_rs1=5.
   - Required: hazard_nop=1 and ifu_stall=1 for 2 cycles, then 0; sb_busy falls after the entry leaves MEM.
2. x0 and no-read cases:
   - Stimulus: issue dec_rd=0 wb_en=1, then decode rs1=0. Separately, dec_rs2 matches with need_rs2=0.
   - Required: hazard_nop stays 0 in both.
3. Redirect:
   - Stimulus: exu_redirect pulse at cycle t, FLUSH_CYCLES=2.
   - Required: flush_nop=1 at t and t+1, 0 at t+2. Instructions killed at t and t+1 do not enter the scoreboard.
4. Memory wait:
   - Stimulus: mem_req=1 for cycles t..t+3, mem_ack=1 at t+3.
   - Required: pipe_stall=1 at t..t+2, 0 at t+3. Scoreboard unchanged through t+2; FSM back to IDLE at t+4.
5. Stall overlap:
   - Stimulus: exu_redirect and a pending RAW hazard, both during pipe_stall=1.
   - Required: flush_nop=0 and hazard_nop=0 while stalled; fcnt not loaded.
6. Async reset:
   - Stimulus: assert rstn=0 mid-WAIT with fcnt=1 and valid entries.
   - Required: all outputs 0 without a clock edge. With PIPE_HAZARD_PERF_EN defined, the counters read 0.
